// File: rtl/obi_magic_mem_bridge.sv
// Bridges one OBI-style req/gnt/rvalid port onto the blocking magic-memory read/write/resp
// handshake, with an in-order request FIFO and a per-access timeout that yields an error response.
module obi_magic_mem_bridge #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned REQ_DEPTH = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    output logic                gnt_o,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic                rvalid_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                mem_read,
    output logic                mem_write,
    output logic [DATA_W/8-1:0] mem_mbe,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_resp,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy_o
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(REQ_DEPTH + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam int unsigned ENT_W = 1 + BE_W + ADDR_W + DATA_W;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StResp   = 2'd2;

    logic [ENT_W-1:0]  fifo_q [REQ_DEPTH];
    logic [ENT_W-1:0]  fifo_d [REQ_DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [TMO_W-1:0]  tmr_q, tmr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              fifo_empty, fifo_full, push, pop, bypass;
    logic              head_we;
    logic [BE_W-1:0]   head_be;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (cnt_q == '0);
    // Fullness uses the registered count, so a same-cycle pop never makes room.
    assign fifo_full  = (cnt_q == CNT_W'(REQ_DEPTH));
    assign gnt_o      = req_i & ~fifo_full;
    assign {head_we, head_be, head_addr, head_wdata} = fifo_q[rptr_q];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmr_d   = tmr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        pop     = 1'b0;
        bypass  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StAccess;
                end else if (gnt_o) begin
                    // Empty and idle: issue straight from the port to get strobe at N+1.
                    bypass  = 1'b1;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                tmr_d = tmr_q + TMO_W'(1);
                if (mem_resp) begin
                    state_d = StResp;
                    rdata_d = we_q ? '0 : mem_rdata;
                    err_d   = 1'b0;
                end else if (tmr_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d = StResp;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = StAccess;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            we_d    = head_we;
            be_d    = head_be;
            addr_d  = {head_addr[ADDR_W-1:2], 2'b00};
            wdata_d = head_wdata;
            tmr_d   = '0;
        end else if (bypass) begin
            we_d    = we_i;
            be_d    = be_i;
            addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = wdata_i;
            tmr_d   = '0;
        end
    end

    always_comb begin
        push   = gnt_o & ~bypass;
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            fifo_d[wptr_q] = {we_i, be_i, addr_i, wdata_i};
            wptr_d         = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmr_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmr_q   <= tmr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign rvalid_o  = (state_q == StResp);
    assign rdata_o   = rvalid_o ? rdata_q : '0;
    assign err_o     = rvalid_o & err_q;
    assign mem_read  = (state_q == StAccess) & ~we_q;
    assign mem_write = (state_q == StAccess) & we_q;
    assign mem_mbe   = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy_o    = ~fifo_empty | (state_q != StIdle);

endmodule
